// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package riscv_lsu_pkg;

   // LSU control states (2-bit encoding).
   typedef enum logic [1:0] {
      LSU_ST_IDLE = 2'd0,
      LSU_ST_REQ  = 2'd1,
      LSU_ST_WAIT = 2'd2,
      LSU_ST_DONE = 2'd3
   } lsu_state_t;

   // Memory funct3 encodings shared with the decoder.
   localparam logic [2:0] FUNCT3_MEM_BYTE  = 3'b000;
   localparam logic [2:0] FUNCT3_MEM_HALF  = 3'b001;
   localparam logic [2:0] FUNCT3_MEM_WORD  = 3'b010;
   localparam logic [2:0] FUNCT3_MEM_BYTEU = 3'b100;
   localparam logic [2:0] FUNCT3_MEM_HALFU = 3'b101;

   // Natural alignment check: bytes always, halves on even, words on 4-byte.
   function automatic logic lsu_aligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b00:   lsu_aligned = 1'b1;
         2'b01:   lsu_aligned = ~off[0];
         default: lsu_aligned = (off == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_load_extend.sv
// Lane select and sign/zero extension of a returned load word.
module riscv_load_extend
   import riscv_lsu_pkg::*;
(
   input  logic [31:0] bus_rdata,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Pick the addressed byte/half and extend it according to funct3.
   always_comb begin
      byte_v = bus_rdata[{lane, 3'b000} +: 8];
      half_v = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (funct3)
         FUNCT3_MEM_BYTE:  data = {{24{byte_v[7]}}, byte_v};
         FUNCT3_MEM_HALF:  data = {{16{half_v[15]}}, half_v};
         FUNCT3_MEM_BYTEU: data = {24'd0, byte_v};
         FUNCT3_MEM_HALFU: data = {16'd0, half_v};
         default:          data = bus_rdata;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit: one valid/ready bus transaction per access.
// Bus handshake: bus_valid rises in REQ with a stable payload and is held
// until the cycle bus_ready is high (the transfer cycle); read data is taken
// in the first cycle bus_rvalid is high at or after that transfer.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_req,
   input  logic            memwrite,
   input  logic [2:0]      funct3,
   input  logic [3:0]      byte_sel,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] rdata,
   output logic            misaligned,
   output logic            bus_err,
   output logic            bus_valid,
   input  logic            bus_ready,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_wstrb,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata
);

   lsu_state_t      state_q, state_d;
   logic [15:0]     tmo_cnt;
   logic            we_q, err_q;
   logic [2:0]      funct3_q;
   logic [1:0]      lane_q;
   logic [3:0]      wstrb_q;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q, ext_data;
   logic            aligned, accept, capture, timeout, tmo_hit;

   assign aligned = lsu_aligned(funct3, addr[1:0]);
   assign accept  = (state_q == LSU_ST_IDLE) && mem_req && aligned;
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

   riscv_load_extend u_ext (
      .bus_rdata (bus_rdata),
      .lane      (lane_q),
      .funct3    (funct3_q),
      .data      (ext_data)
   );

   // Next-state logic; a normal completion wins over a timeout in the same cycle.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      timeout = 1'b0;
      case (state_q)
         LSU_ST_IDLE: if (accept) state_d = LSU_ST_REQ;
         LSU_ST_REQ: begin
            if (bus_ready) begin
               if (we_q) begin
                  state_d = LSU_ST_DONE;
               end else if (bus_rvalid) begin
                  state_d = LSU_ST_DONE;
                  capture = 1'b1;
               end else begin
                  state_d = LSU_ST_WAIT;
               end
            end else if (tmo_hit) begin
               state_d = LSU_ST_DONE;
               timeout = 1'b1;
            end
         end
         LSU_ST_WAIT: begin
            if (bus_rvalid) begin
               state_d = LSU_ST_DONE;
               capture = 1'b1;
            end else if (tmo_hit) begin
               state_d = LSU_ST_DONE;
               timeout = 1'b1;
            end
         end
         default: state_d = LSU_ST_IDLE;
      endcase
   end

   // State, timeout counter, latched request payload and load result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= LSU_ST_IDLE;
         tmo_cnt  <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         lane_q   <= '0;
         wstrb_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == LSU_ST_REQ) || (state_q == LSU_ST_WAIT)) tmo_cnt <= tmo_cnt + 16'd1;
         else tmo_cnt <= '0;
         if (accept) begin
            we_q     <= memwrite;
            funct3_q <= funct3;
            lane_q   <= addr[1:0];
            wstrb_q  <= byte_sel << addr[1:0];
            addr_q   <= {addr[XLEN-1:2], 2'b00};
            wdata_q  <= wdata << {addr[1:0], 3'b000};
            rdata_q  <= '0;
            err_q    <= 1'b0;
         end else if (capture) begin
            rdata_q <= ext_data;
         end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   // Outputs decode from the registered state; reset forces the combinational ones low.
   assign bus_valid  = (state_q == LSU_ST_REQ);
   assign bus_we     = bus_valid & we_q;
   assign bus_addr   = addr_q;
   assign bus_wstrb  = wstrb_q;
   assign bus_wdata  = wdata_q;
   assign done       = (state_q == LSU_ST_DONE);
   assign bus_err    = done & err_q;
   assign rdata      = done ? rdata_q : '0;
   assign misaligned = ~reset & mem_req & (state_q == LSU_ST_IDLE) & ~aligned;
   assign stall      = ~reset & mem_req &
                       ((state_q == LSU_ST_IDLE) ? aligned : (state_q != LSU_ST_DONE));

endmodule

// File: tb/tb_riscv_lsu.sv
// Testbench for riscv_lsu: directed vector table, hand sequences, random traffic.
module tb_riscv_lsu;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rword;
      int          rdy_dly;
      int          rv_dly;
   } txn_t;

   typedef struct {
      txn_t        t;
      logic        exp_mis;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_addr;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic        mis;
      logic        stall0;
      logic        any_valid;
      logic        stable;
      logic        bus_we;
      logic [3:0]  wstrb;
      logic [31:0] wdata_bus;
      logic [31:0] addr_bus;
      logic [31:0] rdata;
      logic        err;
      int          done_c;
      int          stall_cnt;
   } obs_t;

   logic        clk, reset;
   logic        mem_req, mem_req2, memwrite;
   logic [2:0]  funct3;
   logic [3:0]  byte_sel;
   logic [31:0] addr, wdata;
   logic        bus_ready, bus_rvalid;
   logic [31:0] bus_rdata;

   logic        stall, done, misaligned, bus_err, bus_valid, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;

   logic        stall_t, done_t, misaligned_t, bus_err_t, bus_valid_t, bus_we_t;
   logic [31:0] rdata_t, bus_addr_t, bus_wdata_t;
   logic [3:0]  bus_wstrb_t;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   riscv_lsu dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .memwrite(memwrite), .funct3(funct3),
      .byte_sel(byte_sel), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
      .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err), .bus_valid(bus_valid),
      .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
      .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   riscv_lsu #(.TIMEOUT_CYCLES(4)) dut_tmo (
      .clk(clk), .reset(reset), .mem_req(mem_req2), .memwrite(memwrite), .funct3(funct3),
      .byte_sel(byte_sel), .addr(addr), .wdata(wdata), .stall(stall_t), .done(done_t),
      .rdata(rdata_t), .misaligned(misaligned_t), .bus_err(bus_err_t), .bus_valid(bus_valid_t),
      .bus_ready(bus_ready), .bus_we(bus_we_t), .bus_addr(bus_addr_t), .bus_wstrb(bus_wstrb_t),
      .bus_wdata(bus_wdata_t), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: access size and the bus/load values it implies.
   function automatic int unsigned msize(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      else if (f3[1:0] == 2'b01) return 2;
      else return 4;
   endfunction

   function automatic logic [3:0] mbsel(input logic [2:0] f3);
      int unsigned v;
      v = (1 << msize(f3)) - 1;
      return v[3:0];
   endfunction

   function automatic vec_t model(input txn_t t);
      vec_t        r;
      int unsigned off, sz, s;
      logic [63:0] wide;
      logic [31:0] v;
      sz  = msize(t.f3);
      off = t.addr % 4;
      r.t = t;
      r.exp_mis = (t.addr % sz) != 0;
      s = ((1 << sz) - 1) << off;
      r.exp_wstrb = s[3:0];
      wide = {32'd0, t.wdata} << (8 * off);
      r.exp_wdata = wide[31:0];
      r.exp_addr = t.addr - off;
      v = t.rword >> (8 * off);
      if (sz == 1) begin
         v = v & 32'hFF;
         if (!t.f3[2] && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (sz == 2) begin
         v = v & 32'hFFFF;
         if (!t.f3[2] && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      r.exp_rdata = v;
      r.exp_lat = t.we ? 2 + t.rdy_dly : 2 + t.rdy_dly + t.rv_dly;
      return r;
   endfunction

   // Driver: present one access on dut and act as the bus slave.
   task automatic run_txn(input txn_t t, output obs_t o);
      int          hs, vcnt;
      logic        fin, w0;
      logic [31:0] a0, d0;
      logic [3:0]  s0;
      o = '{default: 0};
      o.done_c = -1;
      o.stable = 1'b1;
      hs = -1; vcnt = 0; fin = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0; s0 = '0;
      @(negedge clk);
      mem_req = 1'b1; memwrite = t.we; funct3 = t.f3; byte_sel = mbsel(t.f3);
      addr = t.addr; wdata = t.wdata; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      #1;
      o.mis = misaligned;
      o.stall0 = stall;
      if (misaligned) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_req = 1'b0;
            #1;
            if (bus_valid) o.any_valid = 1'b1;
         end
         return;
      end
      for (int c = 0; c < 300 && !fin; c++) begin
         if (c > 0) @(negedge clk);
         bus_ready = 1'b0;
         bus_rvalid = 1'b0;
         bus_rdata = $urandom;
         if (bus_valid) begin
            o.any_valid = 1'b1;
            if (vcnt == 0) begin
               w0 = bus_we; a0 = bus_addr; s0 = bus_wstrb; d0 = bus_wdata;
            end else if (bus_we !== w0 || bus_addr !== a0 || bus_wstrb !== s0 || bus_wdata !== d0) begin
               o.stable = 1'b0;
            end
            if (vcnt >= t.rdy_dly) begin
               bus_ready = 1'b1;
               hs = c;
            end
            vcnt++;
         end
         if (!t.we && hs >= 0 && c == hs + t.rv_dly) begin
            bus_rvalid = 1'b1;
            bus_rdata = t.rword;
         end
         #1;
         if (stall) o.stall_cnt++;
         if (done) begin
            o.done_c = c;
            o.rdata = rdata;
            o.err = bus_err;
            fin = 1'b1;
         end
      end
      o.bus_we = w0; o.addr_bus = a0; o.wstrb = s0; o.wdata_bus = d0;
      @(negedge clk);
      mem_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
   endtask

   // Scoreboard: compare one observed access against its expected record.
   task automatic check_vec(input string tag, input vec_t v, input obs_t o);
      chk({tag, ".misaligned"}, {31'd0, o.mis}, {31'd0, v.exp_mis});
      if (v.exp_mis) begin
         chk({tag, ".mis_stall"}, {31'd0, o.stall0}, 32'd0);
         chk({tag, ".mis_no_bus"}, {31'd0, o.any_valid}, 32'd0);
      end else begin
         chk({tag, ".latency"}, o.done_c, v.exp_lat);
         chk({tag, ".stall_cycles"}, o.stall_cnt, v.exp_lat);
         chk({tag, ".bus_addr"}, o.addr_bus, v.exp_addr);
         chk({tag, ".bus_wstrb"}, {28'd0, o.wstrb}, {28'd0, v.exp_wstrb});
         chk({tag, ".bus_we"}, {31'd0, o.bus_we}, {31'd0, v.t.we});
         chk({tag, ".payload_stable"}, {31'd0, o.stable}, 32'd1);
         chk({tag, ".bus_err"}, {31'd0, o.err}, 32'd0);
         if (v.t.we) chk({tag, ".bus_wdata"}, o.wdata_bus, v.exp_wdata);
         else begin
            exp_q.push_back(v.exp_rdata);
            chk({tag, ".rdata"}, o.rdata, exp_q.pop_front());
         end
      end
   endtask

   vec_t vecs[10];
   obs_t obs;
   logic [2:0] load_f3[5];
   logic [2:0] store_f3[3];
   txn_t rt;
   logic flag;

   initial begin
      load_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      store_f3 = '{3'b000, 3'b001, 3'b010};
      //            we    f3      addr          wdata         rword       rdy rv   mis   wstrb  wdata         addr          rdata        lat
      vecs[0] = '{'{1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 32'h0,        0, 0}, 1'b0, 4'hF, 32'hDEADBEEF, 32'h00000100, 32'h0,        2};
      vecs[1] = '{'{1'b1, 3'b000, 32'h00000103, 32'h000000A5, 32'h0,        0, 0}, 1'b0, 4'h8, 32'hA5000000, 32'h00000100, 32'h0,        2};
      vecs[2] = '{'{1'b0, 3'b000, 32'h00000101, 32'h0,        32'h00008000, 0, 3}, 1'b0, 4'h2, 32'h0,        32'h00000100, 32'hFFFFFF80, 5};
      vecs[3] = '{'{1'b0, 3'b100, 32'h00000101, 32'h0,        32'h00008000, 0, 3}, 1'b0, 4'h2, 32'h0,        32'h00000100, 32'h00000080, 5};
      vecs[4] = '{'{1'b0, 3'b001, 32'h00000103, 32'h0,        32'h0,        0, 0}, 1'b1, 4'h0, 32'h0,        32'h0,        32'h0,        0};
      vecs[5] = '{'{1'b0, 3'b010, 32'h00000102, 32'h0,        32'h0,        0, 0}, 1'b1, 4'h0, 32'h0,        32'h0,        32'h0,        0};
      vecs[6] = '{'{1'b0, 3'b010, 32'h00000204, 32'h0,        32'h12345678, 3, 0}, 1'b0, 4'hF, 32'h0,        32'h00000204, 32'h12345678, 5};
      vecs[7] = '{'{1'b0, 3'b001, 32'h00000102, 32'h0,        32'h80010000, 1, 1}, 1'b0, 4'hC, 32'h0,        32'h00000100, 32'hFFFF8001, 4};
      vecs[8] = '{'{1'b0, 3'b101, 32'h00000102, 32'h0,        32'h80010000, 0, 0}, 1'b0, 4'hC, 32'h0,        32'h00000100, 32'h00008001, 2};
      vecs[9] = '{'{1'b1, 3'b001, 32'h00000302, 32'h0000BEEF, 32'h0,        2, 0}, 1'b0, 4'hC, 32'hBEEF0000, 32'h00000300, 32'h0,        4};

      // Reset block.
      reset = 1'b1; mem_req = 1'b0; mem_req2 = 1'b0; memwrite = 1'b0; funct3 = '0; byte_sel = '0;
      addr = '0; wdata = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.outputs", {stall, done, misaligned, bus_err, bus_valid, bus_we, bus_wstrb}, 32'd0);
      chk("reset.buses", rdata | bus_addr | bus_wdata, 32'd0);
      chk("reset.tmo_outputs", {stall_t, done_t, misaligned_t, bus_err_t, bus_valid_t}, 32'd0);
      reset = 1'b0;

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i].t, obs);
         check_vec($sformatf("vec%0d", i), vecs[i], obs);
      end

      // rvalid while idle must be ignored.
      @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
      flag = 1'b0;
      repeat (3) begin
         #1;
         if (done || bus_valid || stall) flag = 1'b1;
         @(negedge clk);
      end
      bus_rvalid = 1'b0;
      chk("idle_rvalid_ignored", {31'd0, flag}, 32'd0);

      // Timeout on the short-timeout instance: REQ entered at c=1, DONE at c=5.
      @(negedge clk);
      mem_req2 = 1'b1; memwrite = 1'b0; funct3 = 3'b010; byte_sel = 4'hF; addr = 32'h200;
      bus_ready = 1'b0; bus_rvalid = 1'b0;
      flag = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (done_t) flag = 1'b1;
         if (c == 4) chk("tmo.valid_held", {31'd0, bus_valid_t}, 32'd1);
      end
      chk("tmo.no_early_done", {31'd0, flag}, 32'd0);
      @(negedge clk);
      #1;
      chk("tmo.done", {31'd0, done_t}, 32'd1);
      chk("tmo.bus_err", {31'd0, bus_err_t}, 32'd1);
      chk("tmo.rdata", rdata_t, 32'd0);
      chk("tmo.valid_dropped", {31'd0, bus_valid_t}, 32'd0);
      @(negedge clk);
      mem_req2 = 1'b0;
      #1;
      chk("tmo.pulse_once", {31'd0, done_t | bus_err_t}, 32'd0);

      // Reset while waiting for read data.
      @(negedge clk);
      mem_req = 1'b1; memwrite = 1'b0; funct3 = 3'b010; byte_sel = 4'hF; addr = 32'h300;
      @(negedge clk);
      bus_ready = 1'b1;
      #1;
      chk("rst_wait.in_req", {31'd0, bus_valid}, 32'd1);
      @(negedge clk);
      bus_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_wait.outputs", {stall, done, misaligned, bus_err, bus_valid, bus_we, bus_wstrb}, 32'd0);
      chk("rst_wait.buses", rdata | bus_addr | bus_wdata, 32'd0);
      @(negedge clk);
      reset = 1'b0; mem_req = 1'b0;
      flag = 1'b0;
      repeat (3) begin
         @(negedge clk);
         bus_rvalid = 1'b1;
         #1;
         if (done || bus_valid) flag = 1'b1;
      end
      bus_rvalid = 1'b0;
      chk("rst_wait.no_done", {31'd0, flag}, 32'd0);

      // Randomized accesses against the reference model.
      for (int i = 0; i < 40; i++) begin
         rt.we = 1'($urandom_range(0, 1));
         rt.f3 = rt.we ? store_f3[$urandom_range(0, 2)] : load_f3[$urandom_range(0, 4)];
         rt.addr = $urandom;
         if ($urandom_range(0, 1) == 1) rt.addr[0] = 1'b0;
         rt.wdata = $urandom;
         rt.rword = $urandom;
         rt.rdy_dly = $urandom_range(0, 3);
         rt.rv_dly = $urandom_range(0, 3);
         run_txn(rt, obs);
         check_vec($sformatf("rand%0d", i), model(rt), obs);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
